operand_join_buffer: RTL and testbench

//  Input stage placed directly upstream of the functional unit in each CGRA PE.
//  Two independent operand streams (each valid/ready) are buffered in per-operand FIFOs.

---
 rtl/operand_join_buffer_if.sv | 26 ++
 rtl/operand_join_buffer.sv | 107 ++++++++++
 tb/tb_operand_join_buffer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/operand_join_buffer_if.sv
// Operand join buffer handshake bundle: two operand streams in, one joined beat out.
// slave = the join buffer, master = operand producers plus the FU consumer.
interface operand_join_buffer_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] in1_data;
  logic                  in1_v;
  logic                  in1_r;
  logic [DATA_WIDTH-1:0] in2_data;
  logic                  in2_v;
  logic                  in2_r;
  logic [DATA_WIDTH-1:0] out_data_1;
  logic [DATA_WIDTH-1:0] out_data_2;
  logic                  out_v;
  logic                  out_r;

  modport slave (
    input  in1_data, in1_v, in2_data, in2_v, out_r,
    output in1_r, in2_r, out_data_1, out_data_2, out_v
  );

  modport master (
    output in1_data, in1_v, in2_data, in2_v, out_r,
    input  in1_r, in2_r, out_data_1, out_data_2, out_v
  );
endinterface

// File: rtl/operand_join_buffer.sv
// CGRA PE input stage: per-operand FIFOs joined into one synchronised FU beat.
// Optional JOIN_CONST_OPERAND_EN replaces operand 2 with a configured constant.
module operand_join_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  cfg_in2_en,
`ifdef JOIN_CONST_OPERAND_EN
  input  logic                  cfg_const_en,
  input  logic [DATA_WIDTH-1:0] cfg_const_value,
`endif
  operand_join_buffer_if.slave  bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem1_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem2_q [DEPTH];
  logic [PW-1:0] wptr1_q, wptr1_d, rptr1_q, rptr1_d;
  logic [PW-1:0] wptr2_q, wptr2_d, rptr2_q, rptr2_d;
  logic [CW-1:0] count1_q, count1_d, count2_q, count2_d;

  logic const_use;
  logic op2_fifo_en;
  logic push1, push2, pop1, pop2;

`ifdef JOIN_CONST_OPERAND_EN
  assign const_use = cfg_in2_en && cfg_const_en;
`else
  assign const_use = 1'b0;
`endif
  assign op2_fifo_en = cfg_in2_en && !const_use;

  // Ready depends only on occupancy, so there is no in->out combinational path.
  assign bus.in1_r = (count1_q != FULL);
  assign bus.in2_r = op2_fifo_en && (count2_q != FULL);
  assign bus.out_v = (count1_q != '0) && (!op2_fifo_en || (count2_q != '0));

  assign bus.out_data_1 = mem1_q[rptr1_q];
`ifdef JOIN_CONST_OPERAND_EN
  assign bus.out_data_2 = const_use  ? cfg_const_value :
                          cfg_in2_en ? mem2_q[rptr2_q] : '0;
`else
  assign bus.out_data_2 = cfg_in2_en ? mem2_q[rptr2_q] : '0;
`endif

  assign push1 = bus.in1_v && bus.in1_r;
  assign push2 = bus.in2_v && bus.in2_r;
  assign pop1  = bus.out_v && bus.out_r;
  assign pop2  = pop1 && op2_fifo_en;

  always_comb begin
    wptr1_d  = wptr1_q;
    rptr1_d  = rptr1_q;
    count1_d = count1_q;
    wptr2_d  = wptr2_q;
    rptr2_d  = rptr2_q;
    count2_d = count2_q;
    if (clr) begin
      wptr1_d  = '0;
      rptr1_d  = '0;
      count1_d = '0;
      wptr2_d  = '0;
      rptr2_d  = '0;
      count2_d = '0;
    end else begin
      if (push1) wptr1_d = wptr1_q + PW'(1);
      if (pop1)  rptr1_d = rptr1_q + PW'(1);
      if (push1 && !pop1)      count1_d = count1_q + CW'(1);
      else if (pop1 && !push1) count1_d = count1_q - CW'(1);
      if (push2) wptr2_d = wptr2_q + PW'(1);
      if (pop2)  rptr2_d = rptr2_q + PW'(1);
      if (push2 && !pop2)      count2_d = count2_q + CW'(1);
      else if (pop2 && !push2) count2_d = count2_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr1_q  <= '0;
      rptr1_q  <= '0;
      count1_q <= '0;
      wptr2_q  <= '0;
      rptr2_q  <= '0;
      count2_q <= '0;
    end else begin
      wptr1_q  <= wptr1_d;
      rptr1_q  <= rptr1_d;
      count1_q <= count1_d;
      wptr2_q  <= wptr2_d;
      rptr2_q  <= rptr2_d;
      count2_q <= count2_d;
    end
  end

  // Storage is deliberately left unreset; occupancy counts gate its visibility.
  always_ff @(posedge clk) begin
    if (!clr && push1) mem1_q[wptr1_q] <= bus.in1_data;
    if (!clr && push2) mem2_q[wptr2_q] <= bus.in2_data;
  end

endmodule

// File: tb/tb_operand_join_buffer.sv
// Directed table-driven bench for operand_join_buffer plus a scoreboarded wrap/stream run.
// Define JOIN_CONST_OPERAND_EN for both files to cover the constant-operand mode.
module tb_operand_join_buffer;

  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  logic cfg_in2_en;
  logic cfg_const_en;
  logic [DW-1:0] cfg_const_value;

  int n_vec  = 0;
  int n_miss = 0;

  operand_join_buffer_if #(.DATA_WIDTH(DW)) bus ();

  operand_join_buffer #(.DATA_WIDTH(DW), .DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clr            (clr),
    .cfg_in2_en     (cfg_in2_en),
`ifdef JOIN_CONST_OPERAND_EN
    .cfg_const_en   (cfg_const_en),
    .cfg_const_value(cfg_const_value),
`endif
    .bus            (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          rst;
    bit          clr;
    bit          cfg;
    bit          cen;
    bit          v1;
    logic [31:0] d1;
    bit          v2;
    logic [31:0] d2;
    bit          rdy;
    bit          e_r1;
    bit          e_r2;
    bit          e_v;
    logic [31:0] e_d1;
    logic [31:0] e_d2;
  } vec_t;

  vec_t tab_a[$];
  vec_t tab_b[$];

  function automatic vec_t mk(string n, bit rst, bit c, bit cfg, bit cen,
                              bit v1, logic [31:0] d1, bit v2, logic [31:0] d2, bit rdy,
                              bit r1, bit r2, bit ov, logic [31:0] o1, logic [31:0] o2);
    vec_t v;
    v.name = n; v.rst = rst; v.clr = c; v.cfg = cfg; v.cen = cen;
    v.v1 = v1; v.d1 = d1; v.v2 = v2; v.d2 = d2; v.rdy = rdy;
    v.e_r1 = r1; v.e_r2 = r2; v.e_v = ov; v.e_d1 = o1; v.e_d2 = o2;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, sample outputs before the rising edge.
  task automatic apply_vec(input vec_t v);
    @(negedge clk);
    rst_n        = !v.rst;
    clr          = v.clr;
    cfg_in2_en   = v.cfg;
    cfg_const_en = v.cen;
    bus.in1_v    = v.v1;
    bus.in1_data = v.d1;
    bus.in2_v    = v.v2;
    bus.in2_data = v.d2;
    bus.out_r    = v.rdy;
    #1;
    check({v.name, ".in1_r"}, 32'(bus.in1_r), 32'(v.e_r1));
    check({v.name, ".in2_r"}, 32'(bus.in2_r), 32'(v.e_r2));
    check({v.name, ".out_v"}, 32'(bus.out_v), 32'(v.e_v));
    if (v.e_v) begin
      check({v.name, ".d1"}, bus.out_data_1, v.e_d1);
      check({v.name, ".d2"}, bus.out_data_2, v.e_d2);
    end
  endtask

  logic [63:0] exp_q[$];

  initial begin
    //            name    rst clr cfg cen v1 d1  v2 d2   rdy r1 r2 ov o1  o2
    tab_a.push_back(mk("rst0", 0, 0, 1, 0, 0, 0,  0, 0,   1,  1, 1, 0, 0,  0));
    tab_a.push_back(mk("t1c1", 0, 0, 1, 0, 1, 5,  0, 0,   1,  1, 1, 0, 0,  0));
    tab_a.push_back(mk("t1c2", 0, 0, 1, 0, 0, 0,  0, 0,   1,  1, 1, 0, 0,  0));
    tab_a.push_back(mk("t1c3", 0, 0, 1, 0, 0, 0,  0, 0,   1,  1, 1, 0, 0,  0));
    tab_a.push_back(mk("t1c4", 0, 0, 1, 0, 0, 0,  1, 7,   1,  1, 1, 0, 0,  0));
    tab_a.push_back(mk("t1c5", 0, 0, 1, 0, 0, 0,  0, 0,   1,  1, 1, 1, 5,  7));
    tab_a.push_back(mk("t1c6", 0, 0, 1, 0, 0, 0,  0, 0,   1,  1, 1, 0, 0,  0));
    tab_a.push_back(mk("t2p1", 0, 0, 1, 0, 1, 'h11, 1, 'h21, 0, 1, 1, 0, 0, 0));
    tab_a.push_back(mk("t2p2", 0, 0, 1, 0, 1, 'h12, 1, 'h22, 0, 1, 1, 1, 'h11, 'h21));
    tab_a.push_back(mk("t2p3", 0, 0, 1, 0, 1, 'h13, 1, 'h23, 0, 1, 1, 1, 'h11, 'h21));
    tab_a.push_back(mk("t2p4", 0, 0, 1, 0, 1, 'h14, 1, 'h24, 0, 1, 1, 1, 'h11, 'h21));
    tab_a.push_back(mk("t2f1", 0, 0, 1, 0, 1, 'h15, 0, 0,    0, 0, 0, 1, 'h11, 'h21));
    tab_a.push_back(mk("t2f2", 0, 0, 1, 0, 1, 'h15, 0, 0,    0, 0, 0, 1, 'h11, 'h21));

    tab_b.push_back(mk("t4clr", 0, 1, 0, 0, 0, 0,  0, 0,  1,  1, 0, 0, 0,  0));
    tab_b.push_back(mk("t4a",   0, 0, 0, 0, 1, 10, 1, 55, 1,  1, 0, 0, 0,  0));
    tab_b.push_back(mk("t4b",   0, 0, 0, 0, 1, 11, 1, 56, 1,  1, 0, 1, 10, 0));
    tab_b.push_back(mk("t4c",   0, 0, 0, 0, 1, 12, 1, 57, 1,  1, 0, 1, 11, 0));
    tab_b.push_back(mk("t4d",   0, 0, 0, 0, 0, 0,  1, 58, 1,  1, 0, 1, 12, 0));
    tab_b.push_back(mk("t4e",   0, 0, 0, 0, 0, 0,  0, 0,  1,  1, 0, 0, 0,  0));
    tab_b.push_back(mk("t5clr", 0, 1, 1, 0, 0, 0,  0, 0,  1,  1, 1, 0, 0,  0));
    tab_b.push_back(mk("t5b1",  0, 0, 1, 0, 1, 31, 1, 41, 0,  1, 1, 0, 0,  0));
    tab_b.push_back(mk("t5b2",  0, 0, 1, 0, 1, 32, 1, 42, 0,  1, 1, 1, 31, 41));
    tab_b.push_back(mk("t5b3",  0, 0, 1, 0, 1, 33, 1, 43, 0,  1, 1, 1, 31, 41));
    tab_b.push_back(mk("t5rst", 1, 0, 1, 0, 0, 0,  0, 0,  1,  1, 1, 0, 0,  0));
    tab_b.push_back(mk("t5r1",  0, 0, 1, 0, 0, 0,  0, 0,  1,  1, 1, 0, 0,  0));
    tab_b.push_back(mk("t5r2",  0, 0, 1, 0, 0, 0,  0, 0,  1,  1, 1, 0, 0,  0));
    tab_b.push_back(mk("t5c1",  0, 0, 1, 0, 1, 31, 1, 41, 0,  1, 1, 0, 0,  0));
    tab_b.push_back(mk("t5c2",  0, 0, 1, 0, 1, 32, 1, 42, 0,  1, 1, 1, 31, 41));
    tab_b.push_back(mk("t5c3",  0, 0, 1, 0, 1, 33, 1, 43, 0,  1, 1, 1, 31, 41));
    tab_b.push_back(mk("t5clr2",0, 1, 1, 0, 1, 99, 0, 0,  1,  1, 1, 1, 31, 41));
    tab_b.push_back(mk("t5k1",  0, 0, 1, 0, 0, 0,  1, 77, 0,  1, 1, 0, 0,  0));
    tab_b.push_back(mk("t5k2",  0, 0, 1, 0, 0, 0,  0, 0,  1,  1, 1, 0, 0,  0));
    tab_b.push_back(mk("t5clr3",0, 1, 1, 0, 0, 0,  0, 0,  1,  1, 1, 0, 0,  0));
`ifdef JOIN_CONST_OPERAND_EN
    tab_b.push_back(mk("t6clr", 0, 1, 1, 1, 0, 0,  0, 0,  1,  1, 0, 0, 0,  0));
    tab_b.push_back(mk("t6p",   0, 0, 1, 1, 1, 9,  1, 5,  1,  1, 0, 0, 0,  0));
    tab_b.push_back(mk("t6o",   0, 0, 1, 1, 0, 0,  0, 0,  1,  1, 0, 1, 9,  3));
    tab_b.push_back(mk("t6e",   0, 0, 1, 1, 0, 0,  0, 0,  1,  1, 0, 0, 0,  0));
`endif

    rst_n = 1'b0; clr = 1'b0; cfg_in2_en = 1'b1; cfg_const_en = 1'b0;
    cfg_const_value = 32'd3;
    bus.in1_v = 1'b0; bus.in1_data = '0; bus.in2_v = 1'b0; bus.in2_data = '0;
    bus.out_r = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (tab_a[i]) apply_vec(tab_a[i]);

    // Drain from full while streaming 1..8 in; expect 0x11..0x14 then 1..8 with no bubble.
    begin
      int  nxt;
      bit  done;
      nxt  = 1;
      done = 1'b0;
      for (int k = 0; k < 4; k++) exp_q.push_back({32'(32'h11 + k), 32'(32'h21 + k)});
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
        @(negedge clk);
        bus.out_r    = 1'b1;
        bus.in1_v    = (nxt <= 8);
        bus.in1_data = 32'(nxt);
        bus.in2_v    = (nxt <= 8);
        bus.in2_data = 32'(nxt + 100);
        #1;
        if (exp_q.size() == 0 && nxt > 8) begin
          check("t3.idle_v", 32'(bus.out_v), 32'd0);
          done = 1'b1;
        end else if (exp_q.size() != 0) begin
          check("t3.stream_v", 32'(bus.out_v), 32'd1);
          check("t3.d1", bus.out_data_1, exp_q[0][63:32]);
          check("t3.d2", bus.out_data_2, exp_q[0][31:0]);
          void'(exp_q.pop_front());
        end
        if (bus.in1_v && bus.in1_r) begin
          exp_q.push_back({32'(nxt), 32'(nxt + 100)});
          nxt++;
        end
      end
      if (!done) check("t3.timeout", 32'd1, 32'd0);
    end

    foreach (tab_b[i]) begin
      apply_vec(tab_b[i]);
      if (tab_b[i].name == "t4e") check("t4.count2", 32'(dut.count2_q), 32'd0);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
